// File: rtl/scan_pkg.sv
// Shared constants for the digit refresh scanner: FSM encoding and parameter defaults.
package scan_pkg;

    localparam int TICK_DIV_DEF  = 100000;
    localparam int BLANK_CYC_DEF = 1000;
    localparam int BLINK_DIV_DEF = 500;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

endpackage

// File: rtl/refresh_scan_if.sv
// Display-side bundle of the refresh scanner: digit data/enables in, drive signals out.
interface refresh_scan_if;
    import scan_pkg::*;

    logic [31:0] digits_in;
    logic [7:0]  dig_en;
    logic [7:0]  blink_mask;
    logic [2:0]  rc_out;
    logic [3:0]  digit_out;
    logic        blank_out;
    logic        tick_out;

    modport master (
        output digits_in, dig_en, blink_mask,
        input  rc_out, digit_out, blank_out, tick_out
    );

    modport slave (
        input  digits_in, dig_en, blink_mask,
        output rc_out, digit_out, blank_out, tick_out
    );

endinterface

// File: rtl/tick_gen.sv
// Slot prescaler: counts 0..DIV-1 and raises a registered tick while the count sits at DIV-1.
module tick_gen #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt;

    // tick is registered one count early so it coincides with cnt == DIV-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == W'(DIV - 1)) ? '0 : cnt + W'(1);
            tick <= (cnt == W'(DIV - 2));
        end
    end

endmodule

// File: rtl/refresh_scan.sv
// Multiplexed 8-digit display scanner with per-slot anti-ghost blanking and digit blink.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no digit enabled; anodes off, waiting for a tick with enables
//   ST_BLANK | start of a slot; anodes off for BLANK_CYC cycles
//   ST_SHOW  | digit driven; blanked only by blink phase on masked digits
module refresh_scan
    import scan_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int BLANK_CYC = BLANK_CYC_DEF,
    parameter int BLINK_DIV = BLINK_DIV_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    refresh_scan_if.slave  sif
);

    localparam int BW = $clog2(BLANK_CYC + 1);
    localparam int KW = $clog2(BLINK_DIV + 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);
    localparam logic [KW-1:0] BLINK_LAST = KW'(BLINK_DIV - 1);

    logic          tick;
    logic [1:0]    state, state_nxt;
    logic [2:0]    rc, rc_nxt;
    logic [BW-1:0] blank_cnt, blank_cnt_nxt;
    logic [KW-1:0] blink_cnt, blink_cnt_nxt;
    logic          blink_phase, blink_phase_nxt;
    logic          mask_bit, mask_bit_nxt;
    logic [3:0]    digit_q;
    logic          blank_q;

    // Nearest enabled index strictly above cur (wrapping); returns cur when it is the only one.
    function automatic logic [2:0] next_enabled(input logic [2:0] cur, input logic [7:0] en);
        logic [2:0] idx;
        next_enabled = cur;
        for (int i = 8; i >= 1; i--) begin
            idx = cur + 3'(i);
            if (en[idx]) next_enabled = idx;
        end
    endfunction

    tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_comb begin
        state_nxt       = state;
        rc_nxt          = rc;
        blank_cnt_nxt   = blank_cnt;
        mask_bit_nxt    = mask_bit;
        blink_cnt_nxt   = blink_cnt;
        blink_phase_nxt = blink_phase;

        if (tick) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_nxt   = '0;
                blink_phase_nxt = ~blink_phase;
            end else begin
                blink_cnt_nxt = blink_cnt + KW'(1);
            end
        end

        // Enables and blink mask are only sampled at slot boundaries, except all-off
        if (sif.dig_en == 8'h00) begin
            state_nxt = ST_IDLE;
        end else if (tick) begin
            rc_nxt        = next_enabled((state == ST_IDLE) ? 3'd7 : rc, sif.dig_en);
            state_nxt     = ST_BLANK;
            blank_cnt_nxt = BLANK_LAST;
            mask_bit_nxt  = sif.blink_mask[rc_nxt];
        end else if (state == ST_BLANK) begin
            if (blank_cnt == '0) state_nxt = ST_SHOW;
            else                 blank_cnt_nxt = blank_cnt - BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_BLANK;
            rc          <= 3'd0;
            blank_cnt   <= BLANK_LAST;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            mask_bit    <= 1'b0;
            digit_q     <= 4'd0;
            blank_q     <= 1'b1;
        end else begin
            state       <= state_nxt;
            rc          <= rc_nxt;
            blank_cnt   <= blank_cnt_nxt;
            blink_cnt   <= blink_cnt_nxt;
            blink_phase <= blink_phase_nxt;
            mask_bit    <= mask_bit_nxt;
            digit_q     <= sif.digits_in[{rc, 2'b00} +: 4];
            blank_q     <= (state_nxt != ST_SHOW) | (blink_phase_nxt & mask_bit_nxt);
        end
    end

    assign sif.rc_out    = rc;
    assign sif.digit_out = digit_q;
    assign sif.blank_out = blank_q;
    assign sif.tick_out  = tick;

endmodule

// File: tb/tb_refresh_scan.sv
// Directed bench for refresh_scan at TICK_DIV=4, BLANK_CYC=1, BLINK_DIV=2.
module tb_refresh_scan;

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    refresh_scan_if sif ();

    refresh_scan #(.TICK_DIV(4), .BLANK_CYC(1), .BLINK_DIV(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset, apply enables/mask, release on a falling edge (observation point O_0)
    task automatic start(input logic [7:0] en, input logic [7:0] mask);
        rst_n          = 1'b0;
        sif.dig_en     = en;
        sif.blink_mask = mask;
        go(2);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0] seq2 [5];
        logic       blk4 [11];
        seq2 = '{3'd0, 3'd2, 3'd7, 3'd0, 3'd2};
        blk4 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

        rst_n          = 1'b0;
        sif.digits_in  = 32'h7654_3210;
        sif.dig_en     = 8'hFF;
        sif.blink_mask = 8'h00;
        go(1);
        chk("rst_rc",    sif.rc_out,    0);
        chk("rst_digit", sif.digit_out, 0);
        chk("rst_blank", sif.blank_out, 1);
        chk("rst_tick",  sif.tick_out,  0);

        // All digits: slot k/4, blank on first slot cycle, tick on last
        start(8'hFF, 8'h00);
        for (int k = 0; k < 36; k++) begin
            if (k > 0) go(1);
            chk("t1_rc",    sif.rc_out,    (k / 4) % 8);
            chk("t1_blank", sif.blank_out, (k % 4 == 0) ? 1 : 0);
            chk("t1_tick",  sif.tick_out,  (k % 4 == 3) ? 1 : 0);
            if (k > 0) chk("t1_digit", sif.digit_out, ((k - 1) / 4) % 8);
        end

        // Sparse enables 1000_0101
        start(8'b1000_0101, 8'h00);
        for (int s = 0; s < 5; s++) begin
            chk("t2_rc",    sif.rc_out,    seq2[s]);
            chk("t2_blank", sif.blank_out, 1);
            go(1);
            chk("t2_digit", sif.digit_out, seq2[s]);
            chk("t2_show",  sif.blank_out, 0);
            go(2);
            chk("t2_tick",  sif.tick_out,  1);
            go(1);
        end

        // All enables dropped mid-SHOW, then only digit 4
        start(8'hFF, 8'h00);
        go(5);
        chk("t3_rc_pre",    sif.rc_out,    1);
        chk("t3_blank_pre", sif.blank_out, 0);
        sif.dig_en = 8'h00;
        go(1);
        chk("t3_idle_blank", sif.blank_out, 1);
        chk("t3_idle_rc",    sif.rc_out,    1);
        go(1);
        chk("t3_idle_tick",  sif.tick_out,  1);
        go(1);
        chk("t3_idle_rc2",   sif.rc_out,    1);
        chk("t3_idle_blk2",  sif.blank_out, 1);
        sif.dig_en = 8'h10;
        go(3);
        chk("t3_wait_rc",    sif.rc_out,    1);
        chk("t3_wait_blank", sif.blank_out, 1);
        go(1);
        chk("t3_load_rc",    sif.rc_out,    4);
        chk("t3_load_blank", sif.blank_out, 1);
        go(1);
        chk("t3_show_blank", sif.blank_out, 0);
        chk("t3_show_digit", sif.digit_out, 4);
        go(3);
        chk("t3_next_rc",    sif.rc_out,    4);
        chk("t3_next_blank", sif.blank_out, 1);

        // Blink on digits 0,1 with three digits enabled; mask change waits for a tick
        start(8'h07, 8'h03);
        go(1);
        for (int s = 0; s < 11; s++) begin
            chk("t4_rc",     sif.rc_out,    s % 3);
            chk("t4_blink",  sif.blank_out, blk4[s]);
            go(1);
            chk("t4_blink2", sif.blank_out, blk4[s]);
            if (s < 10) go(3);
        end
        sif.blink_mask = 8'h00;
        go(1);
        chk("t4_mask_held", sif.blank_out, 1);
        go(18);
        chk("t4_mask_rc",  sif.rc_out,    0);
        chk("t4_mask_new", sif.blank_out, 0);

        // Single enabled digit 3
        start(8'h08, 8'h00);
        chk("t5_rc0", sif.rc_out, 0);
        go(4);
        for (int s = 1; s < 5; s++) begin
            chk("t5_rc",    sif.rc_out,    3);
            chk("t5_blank", sif.blank_out, 1);
            go(1);
            chk("t5_show",  sif.blank_out, 0);
            chk("t5_digit", sif.digit_out, 3);
            go(2);
            chk("t5_tick",  sif.tick_out,  1);
            go(1);
        end

        // Asynchronous reset mid-slot at digit 5
        start(8'hFF, 8'h00);
        go(21);
        chk("t6_pre_rc",    sif.rc_out,    5);
        chk("t6_pre_digit", sif.digit_out, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_rc",    sif.rc_out,    0);
        chk("t6_async_digit", sif.digit_out, 0);
        chk("t6_async_blank", sif.blank_out, 1);
        chk("t6_async_tick",  sif.tick_out,  0);
        go(2);
        rst_n = 1'b1;
        chk("t6_rel_blank", sif.blank_out, 1);
        go(1);
        chk("t6_rel_show",  sif.blank_out, 0);
        chk("t6_rel_rc",    sif.rc_out,    0);
        go(3);
        chk("t6_rc1",       sif.rc_out,    1);
        chk("t6_blank1",    sif.blank_out, 1);
        go(1);
        chk("t6_digit1",    sif.digit_out, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
